// File: rtl/hub75_scan_ctrl.sv
// HUB75 1/N-scan panel sequencer: shifts one row of a bit-plane out of the frame
// buffer, then blanks, latches and shows it with binary-weighted on-time.
module hub75_scan_ctrl #(
  parameter int ROW_LEN  = 64,
  parameter int ROW_BITS = 4,
  parameter int BPP      = 4,
  parameter int OE_BASE  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     enable,
  output logic                                     rd_en,
  output logic [ROW_BITS+$clog2(ROW_LEN)-1:0]      rd_addr,
  output logic [((BPP > 1) ? $clog2(BPP) : 1)-1:0] rd_plane,
  input  logic [5:0]                               rd_data,
  output logic [ROW_BITS-1:0]                      sel,
  output logic                                     sclk,
  output logic                                     lat,
  output logic                                     oe_n,
  output logic [2:0]                               rgb0,
  output logic [2:0]                               rgb1,
  output logic                                     frame_done,
  output logic                                     busy
);

  localparam int COL_W   = $clog2(ROW_LEN);
  localparam int ADDR_W  = ROW_BITS + COL_W;
  localparam int PLANE_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int K_W     = COL_W + 2;
  localparam int DISP_W  = $clog2((OE_BASE << (BPP - 1)) + 1);

  localparam logic [K_W-1:0]      K_LAST     = K_W'(2 * ROW_LEN + 1);
  localparam logic [K_W-1:0]      K_RD_END   = K_W'(2 * ROW_LEN);
  localparam logic [K_W-1:0]      K_SCLK_MIN = K_W'(3);
  localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(BPP - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PLANE_W-1:0]  plane_q, plane_d;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [PLANE_W-1:0]  rd_plane_q, rd_plane_d;
  logic [ROW_BITS-1:0] sel_q, sel_d;
  logic                sclk_q, sclk_d;
  logic                lat_q, lat_d;
  logic                oe_n_q, oe_n_d;
  logic [5:0]          rgb_q, rgb_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                in_shift;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    disp_d  = disp_q;
    row_d   = row_q;
    plane_d = plane_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SHIFT;
          k_d     = '0;
          row_d   = '0;
          plane_d = '0;
        end
      end
      S_SHIFT: begin
        if (k_q == K_LAST) state_d = S_BLANK;
        else               k_d     = k_q + K_W'(1);
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_DISPLAY;
        disp_d  = DISP_W'(OE_BASE << plane_q) - DISP_W'(1);
      end
      S_DISPLAY: begin
        if (disp_q == '0) begin
          if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            row_d   = row_q + ROW_BITS'(1);
          end else begin
            plane_d = plane_q + PLANE_W'(1);
          end
          if (enable) begin
            state_d = S_SHIFT;
            k_d     = '0;
          end else begin
            state_d = S_IDLE;
            row_d   = '0;
            plane_d = '0;
          end
        end else begin
          disp_d = disp_q - DISP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    in_shift     = (state_d == S_SHIFT);
    rd_en_d      = in_shift && !k_d[0] && (k_d < K_RD_END);
    rd_addr_d    = rd_en_d ? {row_d, k_d[COL_W:1]} : rd_addr_q;
    rd_plane_d   = rd_en_d ? plane_d : rd_plane_q;
    sclk_d       = in_shift && k_d[0] && (k_d >= K_SCLK_MIN);
    rgb_d        = (state_q == S_SHIFT && k_q[0] && k_q < K_RD_END) ? rd_data : rgb_q;
    sel_d        = (state_d == S_BLANK) ? row_d : sel_q;
    lat_d        = (state_d == S_LATCH);
    oe_n_d       = (state_d != S_DISPLAY);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DISPLAY) && (disp_d == '0) &&
                   (row_q == ROW_LAST) && (plane_q == PLANE_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      disp_q       <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_plane_q   <= '0;
      sel_q        <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      disp_q       <= disp_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_plane_q   <= rd_plane_d;
      sel_q        <= sel_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      rgb_q        <= rgb_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign rd_plane   = rd_plane_q;
  assign sel        = sel_q;
  assign sclk       = sclk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign rgb0       = rgb_q[2:0];
  assign rgb1       = rgb_q[5:3];
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Scan sequencer for one HUB75 64-column, 1/16-scan RGB panel pair (upper and lower halves). It reads pixel bit-planes from the frame buffer one column at a time and shifts them out on the panel data lines. It then blanks, latches and drives row select, and gates OE with binary-weighted on-times for 2^BPP-level brightness per colour. It sits between the frame buffer RAM and the panel pins, and replaces ad-hoc counter logic in the top level.

## Interface

- ROW_LEN, 64: columns per row; power of two.
- ROW_BITS, 4: row-select width; 2^ROW_BITS scan rows.
- BPP, 4: bit-planes per colour.
- OE_BASE, 8: display cycles for plane 0; plane p displays OE_BASE<<p cycles.

- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  run request.
- rd_en  out  1  frame buffer read strobe.
- rd_addr  out  ROW_BITS+log2(ROW_LEN)  {row, column}.
- rd_plane  out  log2(BPP) (min 1)  bit-plane index for the read.
- rd_data  in  6  {b1,g1,r1,b0,g0,r0} for plane rd_plane; valid the cycle after rd_en.
- sel  out  ROW_BITS  panel row address (A..D).
- sclk  out  1  panel shift clock.
- lat  out  1  panel latch/strobe, active high.
- oe_n  out  1  panel output enable, active low.
- rgb0, rgb1  out  3 each  {b,g,r} for upper and lower half.
- frame_done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high in every state except IDLE.

## Operation

- All outputs are registered. Reset values: sel=0, sclk=0, lat=0, oe_n=1, rgb0=rgb1=0, rd_en=0, rd_addr=0, rd_plane=0, frame_done=0, busy=0. Row and plane counters are 0, and the state is IDLE.
- Order within a frame: row 0..2^ROW_BITS-1; within each row, plane 0..BPP-1. Each (row, plane) pass runs SHIFT -> BLANK -> LATCH -> DISPLAY.
- IDLE: oe_n=1, sclk=0. When enable=1, go to SHIFT with row=0 and plane=0.
- SHIFT: lasts 2*ROW_LEN+2 cycles, numbered k=0.., with oe_n=1 throughout.
  - At k=2c (c<ROW_LEN): rd_en=1, rd_addr={row,c}, rd_plane=plane.
  - rd_data returns at k=2c+1 and is registered into rgb0/rgb1. rgb therefore shows column c during k=2c+2 and k=2c+3.
  - sclk=1 during k=2c+3, so the rising edge falls one cycle after the data changes.
  - Exactly ROW_LEN sclk pulses occur per pass, with column 0 first.
  - rd_en=0 and sclk=0 at all other k.
- BLANK: one cycle, oe_n=1, sel updates to the current row. sel changes only here.
- LATCH: one cycle, lat=1, oe_n=1, sclk=0.
- DISPLAY: oe_n=0 for exactly OE_BASE<<plane cycles.
- On the last DISPLAY cycle, advance plane. When the plane wraps from BPP-1 to 0, advance row. When the row wraps from max to 0, frame_done=1 that cycle.
- enable is sampled only in IDLE and on the last DISPLAY cycle.
  - If it is 0 on the last DISPLAY cycle, go to IDLE (oe_n=1 next cycle) and clear the row and plane counters.
  - A deassertion mid-pass always completes the current pass.
- Reset mid-operation overrides everything: next cycle all outputs take their reset values, including oe_n=1 and lat=0.

## Timing

- Read latency is exactly 1 cycle, with no backpressure.
- Pass length = 2*ROW_LEN+4+(OE_BASE<<plane) cycles.
- Frame length = 2^ROW_BITS*(BPP*(2*ROW_LEN+4) + OE_BASE*(2^BPP-1)). Defaults: 16*(4*132+8*15) = 10368 cycles.
- Invariants:
  - lat and oe_n=0 are never high/low in the same cycle.
  - sclk is never 1 outside SHIFT.
  - sel never changes while oe_n=0.
- The DISPLAY counter is wide enough for OE_BASE<<(BPP-1) without overflow.

## Test plan

- Reset: hold rst_n=0 for 3 cycles with enable=1 -> all outputs at reset values, busy=0. First rd_en comes 1 cycle after release, with rd_addr=0 and rd_plane=0.
- Data path: a model RAM returns rd_data = column[5:0] XOR plane -> on each sclk rising edge, {rgb1,rgb0} equals the expected value for columns 0..63 in order, with 64 edges per pass.
- Weighting: in row 0, oe_n low-run lengths are 8, 16, 32, 64. lat pulses exactly once, 1 cycle after the sel update and 1 cycle before oe_n falls.
- Frame: with enable held high, frame_done pulses every 10368 cycles. sel sequence is 0..15 and then wraps to 0.
- Enable drop: deassert enable at SHIFT k=20 of row 3 plane 1 -> pass completes (64 sclk, lat, 16 oe cycles), then IDLE. Re-enable restarts at row 0 plane 0.
- Reset during DISPLAY of plane 3 -> oe_n=1 on the next cycle and no further lat or sclk until restart.
